mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, memory address width.
REQ-002 Parameter DATA_W, default 32, memory data width.
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 p0_req_valid_i / p0_req_ready_o / p0_addr_i  in/out/in  1/1/ADDR_W  requester 0 (PTW) request channel.
REQ-006 p0_resp_valid_o / p0_resp_ready_i / p0_data_o  out/in/out  1/1/DATA_W  requester 0 response channel.
REQ-007 p1_req_valid_i / p1_req_ready_o / p1_addr_i  in/out/in  1/1/ADDR_W  requester 1 (data-side) request channel.
REQ-008 p1_resp_valid_o / p1_resp_ready_i / p1_data_o  out/in/out  1/1/DATA_W  requester 1 response channel.
REQ-009 mem_req_valid_o / mem_req_ready_i / mem_addr_o  out/in/out  1/1/ADDR_W  shared memory request channel.
REQ-010 mem_resp_valid_i / mem_resp_ready_o / mem_data_i  in/out/in  1/1/DATA_W  shared memory response channel.

Function
REQ-011 The block SHALL implement FSM states IDLE, REQ, RESP, with at most one outstanding memory transaction.
REQ-012 In IDLE, if any pX_req_valid_i is high, the block SHALL pick one winner, assert only that winner's pX_req_ready_o combinationally that cycle, latch its address and owner ID, and go to REQ.
REQ-013 pX_req_ready_o SHALL be low in REQ and RESP, and for the loser in IDLE.
REQ-014 In REQ, the block SHALL drive mem_req_valid_o=1 and mem_addr_o=latched address, holding both stable until mem_req_ready_i=1, then go to RESP.
REQ-015 Latency SHALL be exactly one cycle from request acceptance to first mem_req_valid_o.
REQ-016 In RESP, the owner's pX_resp_valid_o SHALL equal mem_resp_valid_i, and mem_resp_ready_o SHALL equal the owner's pX_resp_ready_i.
REQ-017 The non-owner's resp_valid SHALL be 0.
REQ-018 p0_data_o and p1_data_o SHALL both equal mem_data_i combinationally.
REQ-019 On mem_resp_valid_i && owner resp_ready, the block SHALL return to IDLE and set last_grant=owner; a new grant is possible the following cycle.
REQ-020 If the owner's resp_ready is low, the block SHALL stay in RESP indefinitely with no timeout.
REQ-021 Arbitration with both requesters valid in IDLE SHALL follow REQ-028/REQ-029; with a single valid requester, that requester SHALL win regardless of policy.
REQ-022 mem_resp_valid_i arriving in IDLE or REQ SHALL be ignored: mem_resp_ready_o=0 and no pX_resp_valid_o asserted.
REQ-023 A requester dropping valid after being granted SHALL NOT affect the latched transaction.

Reset
REQ-024 On rst=1 at posedge, state SHALL go to IDLE, last_grant to 1 (so port 0 wins the first tie), and latched address/owner to 0.
REQ-025 During and after reset, all valid/ready outputs SHALL be 0 except that pX_req_ready_o follows REQ-012 once out of reset; mem_addr_o SHALL be 0.
REQ-026 Reset mid-transaction SHALL abandon the outstanding transaction; memory is reset by the same rst.

Configuration
REQ-027 Macro MEM_ARB_RR_EN SHALL select the arbitration policy.
REQ-028 With MEM_ARB_RR_EN defined, ties SHALL go to the requester that is not last_grant (round-robin).
REQ-029 Without MEM_ARB_RR_EN, ties SHALL always go to port 0 (fixed priority), and last_grant SHALL be unused.

Structure
REQ-030 FSM state encodings and the requester ID constants (PORT_PTW=0, PORT_DATA=1) SHALL live in the shared TLB definitions header used by ptw/memory.
REQ-031 The tie-break logic SHALL be one sub-module, mem_arb_pick (inputs: two valids, last_grant; output: winner ID), with the policy macro applied inside it.
REQ-032 The total RTL SHALL be 120–400 lines.

Verification (bench: mem_arbiter + memory with root PT 0x0400[0]=0x00000801 and L2 0x0800[0]=0x1000000F)
REQ-033 Scenario single port 0: p0 request addr 0x00000400 -> p0_resp data 0x00000801; p1_resp_valid_o never high.
REQ-034 Scenario single port 1: p1 request addr 0x00000800 -> p1_resp data 0x1000000F; mem_req_valid_o is high exactly one cycle after acceptance.
REQ-035 Scenario tie, both valid every cycle for 4 transactions:
- with MEM_ARB_RR_EN, grant order is 0,1,0,1;
- without it, grant order is 0,0,0,0.
REQ-036 Scenario response backpressure: owner holds resp_ready=0 for 5 cycles -> mem_resp_ready_o=0 and the block stays in RESP; no new grant occurs until the handshake completes.
REQ-037 Scenario rst asserted while in RESP -> next cycle in IDLE with all outputs 0; a fresh p0 read of 0x0400 returns 0x00000801.
REQ-038 Scenario address stability: mem_req_ready_i delayed 3 cycles -> mem_addr_o constant while p0_addr_i changes.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM state encoding
// and the requester ID constants used by the top and the tie-break picker.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    localparam logic PORT_PTW  = 1'b0;
    localparam logic PORT_DATA = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// Tie-break picker for the memory arbiter. Chooses which requester wins
// when the arbiter is idle.
// Configuration macro: MEM_ARB_RR_EN -- when defined, ties alternate away
// from the last granted port (round-robin); when undefined, port 0 always
// wins ties and last_grant is ignored.
module mem_arb_pick
    import mem_arbiter_pkg::*;
(
    input  logic p0_valid,
    input  logic p1_valid,
    input  logic last_grant,
    output logic winner
);

    // A lone requester always wins; only a tie consults the policy.
    always_comb begin
        winner = PORT_PTW;
        if (p0_valid && p1_valid) begin
`ifdef MEM_ARB_RR_EN
            winner = ~last_grant;
`else
            winner = PORT_PTW;
`endif
        end else if (p1_valid) begin
            winner = PORT_DATA;
        end
    end

`ifndef MEM_ARB_RR_EN
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: the page-table walker (port 0) and the data
// side (port 1) share one memory with at most one outstanding transaction.
// Flow is IDLE (grant) -> REQ (issue to memory) -> RESP (route response).
// Configuration macro: MEM_ARB_RR_EN selects round-robin tie-breaking
// (see mem_arb_pick); without it port 0 has fixed priority.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              p0_req_valid_i,
    output logic              p0_req_ready_o,
    input  logic [ADDR_W-1:0] p0_addr_i,
    output logic              p0_resp_valid_o,
    input  logic              p0_resp_ready_i,
    output logic [DATA_W-1:0] p0_data_o,

    input  logic              p1_req_valid_i,
    output logic              p1_req_ready_o,
    input  logic [ADDR_W-1:0] p1_addr_i,
    output logic              p1_resp_valid_o,
    input  logic              p1_resp_ready_i,
    output logic [DATA_W-1:0] p1_data_o,

    output logic              mem_req_valid_o,
    input  logic              mem_req_ready_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_resp_valid_i,
    output logic              mem_resp_ready_o,
    input  logic [DATA_W-1:0] mem_data_i
);

    arb_state_t state;
    logic       owner;
    logic       last_grant;
    logic       winner;
    logic       any_valid;
    logic       in_idle;
    logic       in_resp;
    logic       owner_resp_ready;

    mem_arb_pick u_pick (
        .p0_valid   (p0_req_valid_i),
        .p1_valid   (p1_req_valid_i),
        .last_grant (last_grant),
        .winner     (winner)
    );

    assign any_valid        = p0_req_valid_i | p1_req_valid_i;
    assign in_idle          = (state == IDLE);
    assign in_resp          = (state == RESP);
    assign owner_resp_ready = (owner == PORT_DATA) ? p1_resp_ready_i : p0_resp_ready_i;

    // Grant handshake is combinational so the winner sees ready the same cycle.
    always_comb begin
        p0_req_ready_o = in_idle && p0_req_valid_i && (winner == PORT_PTW);
        p1_req_ready_o = in_idle && p1_req_valid_i && (winner == PORT_DATA);
    end

    // Response path: only the owner sees memory's valid, and memory only sees the owner's ready.
    always_comb begin
        p0_resp_valid_o  = in_resp && (owner == PORT_PTW)  && mem_resp_valid_i;
        p1_resp_valid_o  = in_resp && (owner == PORT_DATA) && mem_resp_valid_i;
        mem_resp_ready_o = in_resp && owner_resp_ready;
        p0_data_o        = mem_data_i;
        p1_data_o        = mem_data_i;
    end

    // Main FSM: latches the winner's address/ID, holds the memory request until accepted,
    // then waits (without timeout) for the owner to take the response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            owner           <= PORT_PTW;
            last_grant      <= PORT_DATA;
            mem_addr_o      <= '0;
            mem_req_valid_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        owner           <= winner;
                        mem_addr_o      <= (winner == PORT_DATA) ? p1_addr_i : p0_addr_i;
                        mem_req_valid_o <= 1'b1;
                        state           <= REQ;
                    end
                end
                REQ: begin
                    if (mem_req_ready_i) begin
                        mem_req_valid_o <= 1'b0;
                        state           <= RESP;
                    end
                end
                RESP: begin
                    if (mem_resp_valid_i && owner_resp_ready) begin
                        last_grant <= owner;
                        state      <= IDLE;
                    end
                end
                default: begin
                    mem_req_valid_o <= 1'b0;
                    state           <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a small behavioural
// memory holding root PT 0x0400 = 0x00000801 and L2 0x0800 = 0x1000000F.
// Tie-order expectations follow MEM_ARB_RR_EN when it is defined.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        p0_req_valid_i, p0_req_ready_o, p0_resp_valid_o, p0_resp_ready_i;
    logic        p1_req_valid_i, p1_req_ready_o, p1_resp_valid_o, p1_resp_ready_i;
    logic [31:0] p0_addr_i, p1_addr_i, p0_data_o, p1_data_o;
    logic        mem_req_valid_o, mem_req_ready_i, mem_resp_valid_i, mem_resp_ready_o;
    logic [31:0] mem_addr_o, mem_data_i;

    int assert_count = 0;
    int fail_count   = 0;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk              (clk),
        .rst              (rst),
        .p0_req_valid_i   (p0_req_valid_i),
        .p0_req_ready_o   (p0_req_ready_o),
        .p0_addr_i        (p0_addr_i),
        .p0_resp_valid_o  (p0_resp_valid_o),
        .p0_resp_ready_i  (p0_resp_ready_i),
        .p0_data_o        (p0_data_o),
        .p1_req_valid_i   (p1_req_valid_i),
        .p1_req_ready_o   (p1_req_ready_o),
        .p1_addr_i        (p1_addr_i),
        .p1_resp_valid_o  (p1_resp_valid_o),
        .p1_resp_ready_i  (p1_resp_ready_i),
        .p1_data_o        (p1_data_o),
        .mem_req_valid_o  (mem_req_valid_o),
        .mem_req_ready_i  (mem_req_ready_i),
        .mem_addr_o       (mem_addr_o),
        .mem_resp_valid_i (mem_resp_valid_i),
        .mem_resp_ready_o (mem_resp_ready_o),
        .mem_data_i       (mem_data_i)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Backstop so a stuck run still ends with a report.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation still running at %0t, required completion earlier", $time);
        $fatal(1, "[TB] timeout");
    end

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        case (a)
            32'h0000_0400: return 32'h0000_0801;
            32'h0000_0800: return 32'h1000_000F;
            default:       return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Memory side of one transaction, entered while the arbiter is in REQ.
    // Accepts the request, returns the stored word, both ports ready.
    task automatic serve(output logic [1:0] rv, output logic [31:0] data, output logic [31:0] addr);
        addr            = mem_addr_o;
        mem_req_ready_i = 1'b1;
        tick();
        mem_req_ready_i  = 1'b0;
        mem_resp_valid_i = 1'b1;
        mem_data_i       = mem_read(addr);
        p0_resp_ready_i  = 1'b1;
        p1_resp_ready_i  = 1'b1;
        #1;
        rv   = {p1_resp_valid_o, p0_resp_valid_o};
        data = p1_resp_valid_o ? p1_data_o : p0_data_o;
        tick();
        mem_resp_valid_i = 1'b0;
        mem_data_i       = '0;
        p0_resp_ready_i  = 1'b0;
        p1_resp_ready_i  = 1'b0;
    endtask

    task automatic test_reset;
        logic [5:0] outs;
        rst = 1'b1;
        tick();
        tick();
        outs = {mem_req_valid_o, mem_resp_ready_o, p0_req_ready_o, p1_req_ready_o, p0_resp_valid_o, p1_resp_valid_o};
        assert_count++;
        if (outs !== 6'b0) begin
            fail_count++;
            $display("[TB] FAIL reset_outputs: got %b expected %b", outs, 6'b0);
        end
        assert_count++;
        if (mem_addr_o !== 32'h0) begin
            fail_count++;
            $display("[TB] FAIL reset_addr: got %h expected %h", mem_addr_o, 32'h0);
        end
        rst = 1'b0;
        mem_resp_valid_i = 1'b1;
        mem_data_i       = 32'h1234_5678;
        p0_resp_ready_i  = 1'b1;
        #1;
        outs = {mem_req_valid_o, mem_resp_ready_o, p0_req_ready_o, p1_req_ready_o, p0_resp_valid_o, p1_resp_valid_o};
        assert_count++;
        if (outs !== 6'b0) begin
            fail_count++;
            $display("[TB] FAIL idle_ignore_resp: got %b expected %b", outs, 6'b0);
        end
        mem_resp_valid_i = 1'b0;
        mem_data_i       = '0;
        p0_resp_ready_i  = 1'b0;
        tick();
    endtask

    task automatic test_single_p0;
        logic [1:0]  rv;
        logic [31:0] data, addr;
        p0_req_valid_i = 1'b1;
        p0_addr_i      = 32'h0000_0400;
        #1;
        assert_count++;
        if ({p1_req_ready_o, p0_req_ready_o} !== 2'b01) begin
            fail_count++;
            $display("[TB] FAIL p0_grant: got %b expected %b", {p1_req_ready_o, p0_req_ready_o}, 2'b01);
        end
        tick();
        p0_req_valid_i = 1'b0;
        p0_addr_i      = '0;
        serve(rv, data, addr);
        assert_count++;
        if (addr !== 32'h0000_0400) begin
            fail_count++;
            $display("[TB] FAIL p0_mem_addr: got %h expected %h", addr, 32'h0000_0400);
        end
        assert_count++;
        if (rv !== 2'b01) begin
            fail_count++;
            $display("[TB] FAIL p0_resp_route: got %b expected %b", rv, 2'b01);
        end
        assert_count++;
        if (data !== 32'h0000_0801) begin
            fail_count++;
            $display("[TB] FAIL p0_data: got %h expected %h", data, 32'h0000_0801);
        end
    endtask

    task automatic test_single_p1;
        logic [1:0]  rv;
        logic [31:0] data, addr;
        p1_req_valid_i = 1'b1;
        p1_addr_i      = 32'h0000_0800;
        #1;
        assert_count++;
        if ({p1_req_ready_o, p0_req_ready_o, mem_req_valid_o} !== 3'b100) begin
            fail_count++;
            $display("[TB] FAIL p1_grant: got %b expected %b", {p1_req_ready_o, p0_req_ready_o, mem_req_valid_o}, 3'b100);
        end
        tick();
        p1_req_valid_i = 1'b0;
        p1_addr_i      = '0;
        assert_count++;
        if (mem_req_valid_o !== 1'b1) begin
            fail_count++;
            $display("[TB] FAIL p1_latency: got %b expected %b", mem_req_valid_o, 1'b1);
        end
        serve(rv, data, addr);
        assert_count++;
        if (addr !== 32'h0000_0800) begin
            fail_count++;
            $display("[TB] FAIL p1_mem_addr: got %h expected %h", addr, 32'h0000_0800);
        end
        assert_count++;
        if (rv !== 2'b10) begin
            fail_count++;
            $display("[TB] FAIL p1_resp_route: got %b expected %b", rv, 2'b10);
        end
        assert_count++;
        if (data !== 32'h1000_000F) begin
            fail_count++;
            $display("[TB] FAIL p1_data: got %h expected %h", data, 32'h1000_000F);
        end
    endtask

    task automatic test_tie;
        logic [1:0]  rv, grant, exp_grant;
        logic [31:0] data, addr, exp_data;
        logic        exp_port;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            p0_req_valid_i = 1'b1;
            p0_addr_i      = 32'h0000_0400;
            p1_req_valid_i = 1'b1;
            p1_addr_i      = 32'h0000_0800;
            #1;
`ifdef MEM_ARB_RR_EN
            exp_port = (i % 2 == 1);
`else
            exp_port = 1'b0;
`endif
            exp_grant = exp_port ? 2'b10 : 2'b01;
            exp_data  = exp_port ? 32'h1000_000F : 32'h0000_0801;
            grant = {p1_req_ready_o, p0_req_ready_o};
            assert_count++;
            if (grant !== exp_grant) begin
                fail_count++;
                $display("[TB] FAIL tie_grant_%0d: got %b expected %b", i, grant, exp_grant);
            end
            tick();
            serve(rv, data, addr);
            assert_count++;
            if (rv !== exp_grant || data !== exp_data) begin
                fail_count++;
                $display("[TB] FAIL tie_resp_%0d: got %b/%h expected %b/%h", i, rv, data, exp_grant, exp_data);
            end
        end
        p0_req_valid_i = 1'b0;
        p1_req_valid_i = 1'b0;
        #1;
    endtask

    task automatic test_backpressure;
        p1_req_valid_i = 1'b1;
        p1_addr_i      = 32'h0000_0800;
        #1;
        tick();
        p1_req_valid_i  = 1'b0;
        p0_req_valid_i  = 1'b1;
        p0_addr_i       = 32'h0000_0400;
        mem_req_ready_i = 1'b1;
        tick();
        mem_req_ready_i  = 1'b0;
        mem_resp_valid_i = 1'b1;
        mem_data_i       = 32'h1000_000F;
        p1_resp_ready_i  = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            assert_count++;
            if ({mem_resp_ready_o, p0_req_ready_o, p1_resp_valid_o, p0_resp_valid_o} !== 4'b0010) begin
                fail_count++;
                $display("[TB] FAIL bp_hold_%0d: got %b expected %b", k,
                         {mem_resp_ready_o, p0_req_ready_o, p1_resp_valid_o, p0_resp_valid_o}, 4'b0010);
            end
            tick();
        end
        p1_resp_ready_i = 1'b1;
        #1;
        assert_count++;
        if (mem_resp_ready_o !== 1'b1 || p1_data_o !== 32'h1000_000F) begin
            fail_count++;
            $display("[TB] FAIL bp_release: got %b/%h expected %b/%h", mem_resp_ready_o, p1_data_o, 1'b1, 32'h1000_000F);
        end
        tick();
        mem_resp_valid_i = 1'b0;
        mem_data_i       = '0;
        p1_resp_ready_i  = 1'b0;
        #1;
        assert_count++;
        if (p0_req_ready_o !== 1'b1) begin
            fail_count++;
            $display("[TB] FAIL bp_regrant: got %b expected %b", p0_req_ready_o, 1'b1);
        end
        p0_req_valid_i = 1'b0;
        #1;
    endtask

    task automatic test_reset_mid;
        logic [1:0]  rv;
        logic [31:0] data, addr;
        logic [5:0]  outs;
        p0_req_valid_i = 1'b1;
        p0_addr_i      = 32'h0000_0400;
        #1;
        tick();
        p0_req_valid_i  = 1'b0;
        mem_req_ready_i = 1'b1;
        tick();
        mem_req_ready_i  = 1'b0;
        mem_resp_valid_i = 1'b1;
        mem_data_i       = 32'h0000_0801;
        p0_resp_ready_i  = 1'b0;
        #1;
        assert_count++;
        if (p0_resp_valid_o !== 1'b1) begin
            fail_count++;
            $display("[TB] FAIL mid_in_resp: got %b expected %b", p0_resp_valid_o, 1'b1);
        end
        rst = 1'b1;
        mem_resp_valid_i = 1'b0;
        mem_data_i       = '0;
        tick();
        rst = 1'b0;
        #1;
        outs = {mem_req_valid_o, mem_resp_ready_o, p0_req_ready_o, p1_req_ready_o, p0_resp_valid_o, p1_resp_valid_o};
        assert_count++;
        if (outs !== 6'b0 || mem_addr_o !== 32'h0) begin
            fail_count++;
            $display("[TB] FAIL mid_reset_outs: got %b/%h expected %b/%h", outs, mem_addr_o, 6'b0, 32'h0);
        end
        p0_req_valid_i = 1'b1;
        p0_addr_i      = 32'h0000_0400;
        #1;
        assert_count++;
        if (p0_req_ready_o !== 1'b1) begin
            fail_count++;
            $display("[TB] FAIL mid_idle_grant: got %b expected %b", p0_req_ready_o, 1'b1);
        end
        tick();
        p0_req_valid_i = 1'b0;
        serve(rv, data, addr);
        assert_count++;
        if (rv !== 2'b01 || data !== 32'h0000_0801) begin
            fail_count++;
            $display("[TB] FAIL mid_fresh_read: got %b/%h expected %b/%h", rv, data, 2'b01, 32'h0000_0801);
        end
    endtask

    task automatic test_addr_stable;
        logic [1:0]  rv;
        logic [31:0] data, addr;
        p0_req_valid_i = 1'b1;
        p0_addr_i      = 32'h0000_0400;
        #1;
        tick();
        p0_req_valid_i   = 1'b0;
        mem_resp_valid_i = 1'b1;
        mem_data_i       = 32'hBAD0_0000;
        for (int k = 0; k < 3; k++) begin
            p0_addr_i = 32'h0000_1230 + k;
            #1;
            assert_count++;
            if (mem_addr_o !== 32'h0000_0400 || mem_req_valid_o !== 1'b1) begin
                fail_count++;
                $display("[TB] FAIL stable_%0d: got %h/%b expected %h/%b", k, mem_addr_o, mem_req_valid_o, 32'h0000_0400, 1'b1);
            end
            assert_count++;
            if ({mem_resp_ready_o, p1_resp_valid_o, p0_resp_valid_o} !== 3'b000) begin
                fail_count++;
                $display("[TB] FAIL req_ignore_resp_%0d: got %b expected %b", k,
                         {mem_resp_ready_o, p1_resp_valid_o, p0_resp_valid_o}, 3'b000);
            end
            tick();
        end
        mem_resp_valid_i = 1'b0;
        mem_data_i       = '0;
        p0_addr_i        = '0;
        serve(rv, data, addr);
        assert_count++;
        if (addr !== 32'h0000_0400 || rv !== 2'b01 || data !== 32'h0000_0801) begin
            fail_count++;
            $display("[TB] FAIL stable_final: got %h/%b/%h expected %h/%b/%h", addr, rv, data,
                     32'h0000_0400, 2'b01, 32'h0000_0801);
        end
    endtask

    initial begin
        rst              = 1'b1;
        p0_req_valid_i   = 1'b0;
        p1_req_valid_i   = 1'b0;
        p0_addr_i        = '0;
        p1_addr_i        = '0;
        p0_resp_ready_i  = 1'b0;
        p1_resp_ready_i  = 1'b0;
        mem_req_ready_i  = 1'b0;
        mem_resp_valid_i = 1'b0;
        mem_data_i       = '0;

        test_reset();
        test_single_p0();
        test_single_p1();
        test_tie();
        test_backpressure();
        test_reset_mid();
        test_addr_stable();

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
